// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: timestamps every change of the CPU a0 value into a FWFT FIFO
module a0_trace_fifo #(
  parameter int DATA_WIDTH = 17,
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH      = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        a0,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic [DROP_WIDTH-1:0]        dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = TS_WIDTH + DATA_WIDTH;
  logic [RW-1:0]         mem_q [DEPTH];
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic                  primed_q, primed_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_WIDTH-1:0] dropped_q, dropped_d;
  logic                  ev, full, pop, push, drop;
  // event detection, push/pop arbitration and next-state computation
  always_comb begin
    ev         = !primed_q || (a0 != prev_q);
    full       = count_q == CW'(DEPTH);
    pop        = (count_q != '0) && out_ready;
    push       = ev && (!full || pop);
    drop       = ev && full && !pop;
    ts_d       = ts_q + TS_WIDTH'(1);
    primed_d   = 1'b1;
    prev_d     = a0;
    wptr_d     = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + AW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q || drop;
    dropped_d  = (drop && dropped_q != '1) ? dropped_q + DROP_WIDTH'(1) : dropped_q;
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      primed_q   <= 1'b0;
      prev_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      ts_q       <= ts_d;
      primed_q   <= primed_d;
      prev_q     <= prev_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end
  // record storage, written at the tail; no reset needed on the cells
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wptr_q] <= {ts_q, a0};
  end
  assign out_data  = mem_q[rptr_q];
  assign out_valid = count_q != '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign dropped   = dropped_q;
endmodule

// File: tb/tb_a0_trace_fifo.sv
// tb_a0_trace_fifo: directed checks of the a0 trace FIFO
module tb_a0_trace_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [16:0] a0 = '0;
  logic [32:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  dropped;
  logic        rst_w = 1'b0;
  logic [16:0] a0_w = '0;
  logic [20:0] out_data_w;
  logic        out_valid_w;
  logic        out_ready_w = 1'b1;
  logic [3:0]  count_w;
  logic        overflow_w;
  logic [7:0]  dropped_w;
  int vectors = 0;
  int miscompares = 0;

  a0_trace_fifo dut (
    .clk(clk), .rst(rst), .a0(a0), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .overflow(overflow), .dropped(dropped)
  );

  a0_trace_fifo #(.TS_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst_w), .a0(a0_w), .out_data(out_data_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .count(count_w), .overflow(overflow_w), .dropped(dropped_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [32:0] rec(input int ts, input int v);
    return {16'(ts), 17'(v)};
  endfunction

  initial begin
    // TS_WIDTH=4 wrap: a0 change in cycle 17 carries timestamp 1
    rst_w = 1'b1;
    step();
    rst_w = 1'b0;
    a0_w = 17'd0;
    for (int i = 0; i < 17; i++) step();
    a0_w = 17'd3;
    step();
    chk("wrap_valid", 64'(out_valid_w), 64'd1);
    chk("wrap_data", 64'(out_data_w), 64'({4'd1, 17'd3}));

    // test 1: reset state and constant a0
    a0 = 17'd0;
    out_ready = 1'b0;
    do_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_dropped", 64'(dropped), 64'd0);
    for (int i = 0; i < 10; i++) step();
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_data", 64'(out_data), 64'(rec(0, 0)));
    chk("t1_overflow", 64'(overflow), 64'd0);

    // test 2: 11 events into an 8-deep FIFO
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      a0 = 17'(i);
      step();
    end
    chk("t2_count", 64'(count), 64'd8);
    chk("t2_overflow", 64'(overflow), 64'd1);
    chk("t2_dropped", 64'(dropped), 64'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_pop_valid", 64'(out_valid), 64'd1);
      chk("t2_pop_data", 64'(out_data), 64'(rec(i, i)));
      step();
    end
    chk("t2_empty", 64'(out_valid), 64'd0);

    // test 3: continuous changes with a ready consumer
    out_ready = 1'b1;
    a0 = 17'd100;
    do_reset();
    step();
    for (int k = 1; k <= 20; k++) begin
      chk("t3_valid", 64'(out_valid), 64'd1);
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_data", 64'(out_data), 64'(rec(k - 1, 99 + k)));
      a0 = 17'(100 + k);
      step();
    end
    chk("t3_overflow", 64'(overflow), 64'd0);

    // test 4: simultaneous push and pop while full
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a0 = 17'(i);
      step();
    end
    chk("t4_full", 64'(count), 64'd8);
    a0 = 17'd50;
    out_ready = 1'b1;
    step();
    chk("t4_count", 64'(count), 64'd8);
    chk("t4_dropped", 64'(dropped), 64'd0);
    chk("t4_overflow", 64'(overflow), 64'd0);
    for (int i = 1; i < 8; i++) begin
      chk("t4_pop", 64'(out_data), 64'(rec(i, i)));
      step();
    end
    chk("t4_last", 64'(out_data), 64'(rec(8, 50)));
    step();
    chk("t4_empty", 64'(out_valid), 64'd0);

    // test 5: backpressure holds the head steady
    out_ready = 1'b0;
    do_reset();
    for (int i = 5; i <= 7; i++) begin
      a0 = 17'(i);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_data", 64'(out_data), 64'(rec(0, 5)));
      chk("t5_hold_count", 64'(count), 64'd3);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_pop", 64'(out_data), 64'(rec(i, 5 + i)));
      step();
    end
    chk("t5_empty", 64'(out_valid), 64'd0);

    // test 6: reset mid-operation
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a0 = 17'(i);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
    chk("t6_pre_count", 64'(count), 64'd5);
    chk("t6_pre_overflow", 64'(overflow), 64'd1);
    a0 = 17'h1ABCD;
    do_reset();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_dropped", 64'(dropped), 64'd0);
    step();
    chk("t6_count1", 64'(count), 64'd1);
    chk("t6_data", 64'(out_data), 64'(rec(0, 'h1ABCD)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
